// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared op codes, flag indices and result-buffer entry type for the FP writeback stage
package fpu_pkg;

    localparam logic [4:0] OP_FADD = 5'b01010;
    localparam logic [4:0] OP_FSUB = 5'b01011;
    localparam logic [4:0] OP_FMUL = 5'b01100;
    localparam logic [4:0] OP_FDIV = 5'b01101;

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    localparam int FF_NV = 4;
    localparam int FF_DZ = 3;
    localparam int FF_OF = 2;
    localparam int FF_UF = 1;
    localparam int FF_NX = 0;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [4:0]  flags;
    } entry_t;

    function automatic logic is_fp_op(input logic [4:0] op);
        return (op == OP_FADD) || (op == OP_FSUB) || (op == OP_FMUL) || (op == OP_FDIV);
    endfunction

endpackage

// File: rtl/fpu_wb_stage_if.sv
// rtl/fpu_wb_stage_if.sv - upstream result / regfile writeback / fflags bundle with modports
interface fpu_wb_stage_if (input logic clk);
    logic        valid;
    logic        ready;
    logic [4:0]  alu_op;
    logic [4:0]  rd_addr;
    logic [31:0] fpu_data;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        fflags_clr;
    logic [4:0]  fflags;

    modport master (
        input  clk, ready, wb_valid, wb_rd, wb_data, fflags,
        output valid, alu_op, rd_addr, fpu_data, wb_ready, fflags_clr
    );

    modport slave (
        input  clk, valid, alu_op, rd_addr, fpu_data, wb_ready, fflags_clr,
        output ready, wb_valid, wb_rd, wb_data, fflags
    );
endinterface

// File: rtl/fpu_nan_classify.sv
// rtl/fpu_nan_classify.sv - combinational IEEE-754 single classifier and NaN canonicaliser
module fpu_nan_classify
    import fpu_pkg::*;
(
    input  logic [31:0] i_data,
    output logic        o_is_nan,
    output logic        o_is_inf,
    output logic        o_is_subnormal,
    output logic [31:0] o_data
);
    logic exp_all_ones;
    logic exp_zero;
    logic mant_zero;

    assign exp_all_ones   = (i_data[30:23] == 8'hFF);
    assign exp_zero       = (i_data[30:23] == 8'h00);
    assign mant_zero      = (i_data[22:0] == 23'd0);

    assign o_is_nan       = exp_all_ones & ~mant_zero;
    assign o_is_inf       = exp_all_ones & mant_zero;
    assign o_is_subnormal = exp_zero & ~mant_zero;
    assign o_data         = o_is_nan ? CANON_NAN : i_data;
endmodule

// File: rtl/fpu_wb_stage.sv
// rtl/fpu_wb_stage.sv - FP result buffer feeding the FP regfile; sticky fflags under FPU_FFLAGS_EN
module fpu_wb_stage
    import fpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [4:0]  i_alu_op,
    input  logic [4:0]  i_rd_addr,
    input  logic [31:0] i_fpu_data,
    output logic        o_wb_valid,
    input  logic        i_wb_ready,
    output logic [4:0]  o_wb_rd,
    output logic [31:0] o_wb_data,
    input  logic        i_fflags_clr,
    output logic [4:0]  o_fflags
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [4:0]      fflags_q, fflags_d;

    logic            push;
    logic            pop;
    entry_t          head;
    entry_t          new_entry;
    logic            is_nan, is_inf, is_sub;
    logic [31:0]     canon_data;

    fpu_nan_classify u_classify (
        .i_data         (i_fpu_data),
        .o_is_nan       (is_nan),
        .o_is_inf       (is_inf),
        .o_is_subnormal (is_sub),
        .o_data         (canon_data)
    );

    // Readiness comes from the registered count only, so a full buffer never
    // accepts on the same cycle it drains.
    assign o_ready    = (count_q < DEPTH_C);
    assign o_wb_valid = (count_q != '0);
    assign head       = mem_q[rd_ptr_q];
    assign o_wb_rd    = o_wb_valid ? head.rd : 5'd0;
    assign o_wb_data  = o_wb_valid ? head.data : 32'd0;
    assign push       = i_valid & o_ready & is_fp_op(i_alu_op);
    assign pop        = o_wb_valid & i_wb_ready;

    always_comb begin
        new_entry       = '0;
        new_entry.rd    = i_rd_addr;
        new_entry.data  = canon_data;
`ifdef FPU_FFLAGS_EN
        new_entry.flags[FF_NV] = is_nan;
        new_entry.flags[FF_DZ] = 1'b0;
        new_entry.flags[FF_OF] = is_inf;
        new_entry.flags[FF_UF] = is_sub;
        new_entry.flags[FF_NX] = 1'b0;
`endif
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = new_entry;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

`ifdef FPU_FFLAGS_EN
    // Clear applies first so a simultaneous pop still leaves its own flags.
    always_comb begin
        fflags_d = i_fflags_clr ? 5'd0 : fflags_q;
        if (pop) begin
            fflags_d = fflags_d | head.flags;
        end
    end
`else
    logic [8:0] unused_flag_path;
    assign unused_flag_path = {i_fflags_clr, head.flags, is_nan, is_inf, is_sub};
    assign fflags_d         = 5'd0;
`endif

    assign o_fflags = fflags_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            fflags_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            fflags_q <= fflags_d;
            mem_q    <= mem_d;
        end
    end
endmodule

// File: tb/tb_fpu_wb_stage.sv
// tb/tb_fpu_wb_stage.sv - scoreboard bench for fpu_wb_stage: directed scenarios then randomized traffic
module tb_fpu_wb_stage;
    localparam int DEPTH = 2;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [4:0]  flags;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    fpu_wb_stage_if bus (.clk(clk));

    fpu_wb_stage #(.DEPTH(DEPTH)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_valid      (bus.valid),
        .o_ready      (bus.ready),
        .i_alu_op     (bus.alu_op),
        .i_rd_addr    (bus.rd_addr),
        .i_fpu_data   (bus.fpu_data),
        .o_wb_valid   (bus.wb_valid),
        .i_wb_ready   (bus.wb_ready),
        .o_wb_rd      (bus.wb_rd),
        .o_wb_data    (bus.wb_data),
        .i_fflags_clr (bus.fflags_clr),
        .o_fflags     (bus.fflags)
    );

    always #5 clk = ~clk;

    exp_t       sb[$];
    int         outstanding = 0;
    logic [4:0] exp_fflags  = 5'd0;
    int         checks      = 0;
    int         failures    = 0;

    function automatic bit op_is_fp(input logic [4:0] op);
        return op == 5'b01010 || op == 5'b01011 || op == 5'b01100 || op == 5'b01101;
    endfunction

    function automatic exp_t model(input logic [4:0] rd, input logic [31:0] d);
        exp_t e;
        int   ex  = int'(d[30:23]);
        int   man = int'(d[22:0]);
        bit   nan = (ex == 255) && (man != 0);
        bit   inf = (ex == 255) && (man == 0);
        bit   sub = (ex == 0) && (man != 0);
        e.rd    = rd;
        e.data  = nan ? 32'h7FC0_0000 : d;
        e.flags = 5'd0;
`ifdef FPU_FFLAGS_EN
        e.flags = {nan, 1'b0, inf, sub, 1'b0};
`endif
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // One clock of stimulus; the expected entry joins the scoreboard on the edge it is accepted.
    task automatic cyc(input logic v, input logic [4:0] op, input logic [4:0] rd,
                       input logic [31:0] d, input logic wr, input logic clr, input logic r);
        bit will_push;
        bit will_pop;
        bus.valid      = v;
        bus.alu_op     = op;
        bus.rd_addr    = rd;
        bus.fpu_data   = d;
        bus.wb_ready   = wr;
        bus.fflags_clr = clr;
        rst            = r;
        will_pop  = (outstanding > 0) && wr;
        will_push = !r && v && op_is_fp(op) && (outstanding < DEPTH);
        @(posedge clk);
        if (r) begin
            outstanding = 0;
        end else begin
            if (will_push) sb.push_back(model(rd, d));
            outstanding = outstanding + int'(will_push) - int'(will_pop);
        end
        #1;
    endtask

    task automatic idle(input logic wr, input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 5'd0, 5'd0, 32'd0, wr, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] rand_data();
        logic [31:0] d = $urandom;
        case ($urandom_range(0, 5))
            0: d = {d[31], 8'hFF, 23'($urandom_range(1, 23'h7F_FFFF))};
            1: d = {d[31], 8'hFF, 23'd0};
            2: d = {d[31], 8'h00, 23'($urandom_range(1, 23'h7F_FFFF))};
            3: d = {d[31], 31'd0};
            default: ;
        endcase
        return d;
    endfunction

    // Monitor: compares DUT outputs against the scoreboard head every cycle.
    initial begin
        bit exp_valid;
        @(posedge clk);
        forever begin
            @(negedge clk);
            exp_valid = (sb.size() != 0);
            check("wb_valid", 32'(bus.wb_valid), 32'(exp_valid));
            check("ready", 32'(bus.ready), 32'(sb.size() < DEPTH));
            check("wb_rd", 32'(bus.wb_rd), exp_valid ? 32'(sb[0].rd) : 32'd0);
            check("wb_data", bus.wb_data, exp_valid ? sb[0].data : 32'd0);
            check("fflags", 32'(bus.fflags), 32'(exp_fflags));
            if (rst) begin
                sb.delete();
                exp_fflags = 5'd0;
            end else begin
                if (bus.fflags_clr) exp_fflags = 5'd0;
                if (exp_valid && bus.wb_ready) begin
                    exp_fflags = exp_fflags | sb[0].flags;
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        logic [4:0] fp_ops [4] = '{5'b01010, 5'b01011, 5'b01100, 5'b01101};
        logic [4:0] op;
        cyc(1'b0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 5'b01010, 5'd7, 32'h1234_5678, 1'b1, 1'b0, 1'b1);
        idle(1'b1, 1);

        cyc(1'b1, 5'b01010, 5'd3, 32'h3F80_0000, 1'b1, 1'b0, 1'b0);
        idle(1'b1, 2);

        cyc(1'b1, 5'b01100, 5'd1, 32'h4000_0000, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 5'b01100, 5'd2, 32'h4040_0000, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 5'b01100, 5'd4, 32'h4080_0000, 1'b0, 1'b0, 1'b0);
        idle(1'b1, 3);

        cyc(1'b1, 5'b01101, 5'd9, 32'hFFC1_2345, 1'b1, 1'b0, 1'b0);
        idle(1'b1, 2);

        cyc(1'b1, 5'b01011, 5'd10, 32'h7F80_0000, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 5'b01010, 5'd11, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 5'd0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 5'd0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b0);
        idle(1'b0, 2);

        cyc(1'b1, 5'b00000, 5'd12, 32'h3F80_0000, 1'b1, 1'b0, 1'b0);
        idle(1'b1, 2);

        cyc(1'b1, 5'b01010, 5'd13, 32'h7F80_0000, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 5'b01100, 5'd14, 32'hFF80_0001, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 5'd0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b1);
        idle(1'b1, 2);

        for (int i = 0; i < 1500; i++) begin
            op = ($urandom_range(0, 4) != 0) ? fp_ops[$urandom_range(0, 3)] : 5'($urandom);
            cyc(1'($urandom_range(0, 3) != 0), op, 5'($urandom), rand_data(),
                1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0),
                1'($urandom_range(0, 99) == 0));
        end

        idle(1'b1, DEPTH + 2);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
